// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared types and widths for the pipeline controller |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
package pipe_ctrl_pkg;

    localparam int LOAD_WIDTH    = 3;
    localparam int REG_IDX_W     = 5;
    localparam int CNT_WIDTH_DEF = 32;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_if : hazard inputs and stall/bubble controls of the core  |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
interface pipe_ctrl_if;

    logic [pipe_ctrl_pkg::REG_IDX_W-1:0]  FD_rs1_i;
    logic [pipe_ctrl_pkg::REG_IDX_W-1:0]  FD_rs2_i;
    logic                                 FD_use_rs1_i;
    logic                                 FD_use_rs2_i;
    logic [pipe_ctrl_pkg::LOAD_WIDTH-1:0] DD_load_op_i;
    logic                                 DD_need_dstE_i;
    logic [pipe_ctrl_pkg::REG_IDX_W-1:0]  DD_dstE_i;
    logic                                 E_mispredict_i;
    logic                                 M_req_i;
    logic                                 M_ack_i;

    logic PC_stall_o;
    logic F_stall_o;
    logic D_stall_o;
    logic E_stall_o;
    logic F_bubble_o;
    logic D_bubble_o;
    logic M_bubble_o;

    modport master (
        input  FD_rs1_i, FD_rs2_i, FD_use_rs1_i, FD_use_rs2_i,
        input  DD_load_op_i, DD_need_dstE_i, DD_dstE_i,
        input  E_mispredict_i, M_req_i, M_ack_i,
        output PC_stall_o, F_stall_o, D_stall_o, E_stall_o,
        output F_bubble_o, D_bubble_o, M_bubble_o
    );

    modport slave (
        output FD_rs1_i, FD_rs2_i, FD_use_rs1_i, FD_use_rs2_i,
        output DD_load_op_i, DD_need_dstE_i, DD_dstE_i,
        output E_mispredict_i, M_req_i, M_ack_i,
        input  PC_stall_o, F_stall_o, D_stall_o, E_stall_o,
        input  F_bubble_o, D_bubble_o, M_bubble_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_hazard_detect : combinational load-use hazard detection  |
// | Revision                : 1.0                                      |
// +--------------------------------------------------------------------+
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  wire logic [REG_IDX_W-1:0]  fd_rs1_i,
    input  wire logic [REG_IDX_W-1:0]  fd_rs2_i,
    input  wire logic                  fd_use_rs1_i,
    input  wire logic                  fd_use_rs2_i,
    input  wire logic [LOAD_WIDTH-1:0] dd_load_op_i,
    input  wire logic                  dd_need_dst_i,
    input  wire logic [REG_IDX_W-1:0]  dd_dst_i,
    output logic                       lu_o
);

    logic load_writes;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired, so a load targeting it never creates a dependency
    assign load_writes = (dd_load_op_i != '0) && dd_need_dst_i && (dd_dst_i != '0);
    assign rs1_hit     = fd_use_rs1_i && (fd_rs1_i == dd_dst_i);
    assign rs2_hit     = fd_use_rs2_i && (fd_rs2_i == dd_dst_i);
    assign lu_o        = load_writes && (rs1_hit || rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl : stall/bubble controller with memory-wait FSM, counters |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int MEM_TIMEOUT = 255
) (
    input  wire logic       clk_i,
    input  wire logic       rst,
    pipe_ctrl_if.master     bus,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o,
    output logic            err_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(MEM_TIMEOUT);

    state_e                 state_q;
    logic [WAIT_W-1:0]      wait_q;
    logic [WAIT_W-1:0]      wait_d;
    logic                   err_q;
    logic [CNT_WIDTH-1:0]   stall_cnt_q;
    logic [CNT_WIDTH-1:0]   flush_cnt_q;

    logic lu;
    logic mw;
    logic flush;
    logic any_stall;

    pipe_ctrl_hazard_detect u_hazard_detect (
        .fd_rs1_i     (bus.FD_rs1_i),
        .fd_rs2_i     (bus.FD_rs2_i),
        .fd_use_rs1_i (bus.FD_use_rs1_i),
        .fd_use_rs2_i (bus.FD_use_rs2_i),
        .dd_load_op_i (bus.DD_load_op_i),
        .dd_need_dst_i(bus.DD_need_dstE_i),
        .dd_dst_i     (bus.DD_dstE_i),
        .lu_o         (lu)
    );

    // In MEM_WAIT a dropped request is a protocol violation that releases the
    // stall, so both states reduce to the same wait condition.
    assign mw        = bus.M_req_i & ~bus.M_ack_i;
    assign flush     = bus.E_mispredict_i & ~mw;
    assign any_stall = mw | (lu & ~bus.E_mispredict_i);
    assign wait_d    = (wait_q == c_wait_max) ? wait_q : wait_q + WAIT_W'(1);

    always_comb begin
        bus.PC_stall_o = 1'b0;
        bus.F_stall_o  = 1'b0;
        bus.D_stall_o  = 1'b0;
        bus.E_stall_o  = 1'b0;
        bus.F_bubble_o = 1'b0;
        bus.D_bubble_o = 1'b0;
        bus.M_bubble_o = 1'b0;
        if (!rst) begin
            bus.F_bubble_o = 1'b1;
            bus.D_bubble_o = 1'b1;
            bus.M_bubble_o = 1'b1;
        end else if (mw) begin
            bus.PC_stall_o = 1'b1;
            bus.F_stall_o  = 1'b1;
            bus.D_stall_o  = 1'b1;
            bus.E_stall_o  = 1'b1;
            bus.M_bubble_o = 1'b1;
        end else if (bus.E_mispredict_i) begin
            bus.F_bubble_o = 1'b1;
            bus.D_bubble_o = 1'b1;
        end else if (lu) begin
            bus.PC_stall_o = 1'b1;
            bus.F_stall_o  = 1'b1;
            bus.D_bubble_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (any_stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
            case (state_q)
                ST_RUN: begin
                    if (mw) begin
                        state_q <= ST_MEM_WAIT;
                        wait_q  <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.M_ack_i) begin
                        state_q <= ST_RUN;
                    end else if (!bus.M_req_i) begin
                        state_q <= ST_RUN;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_d;
                        if (wait_d == c_wait_max) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_ctrl : scoreboard bench for the pipeline stall controller   |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_pipe_ctrl;

    localparam int CNT_WIDTH   = 32;
    localparam int MEM_TIMEOUT = 4;

    // {PC_stall, F_stall, D_stall, E_stall, F_bubble, D_bubble, M_bubble}
    localparam logic [6:0] c_none = 7'b0000_000;
    localparam logic [6:0] c_lu   = 7'b1100_010;
    localparam logic [6:0] c_mw   = 7'b1111_001;
    localparam logic [6:0] c_fl   = 7'b0000_110;
    localparam logic [6:0] c_rst  = 7'b0000_111;

    logic                 clk_i;
    logic                 rst;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;
    logic                 err_o;

    int checks   = 0;
    int failures = 0;

    logic [6:0] sb_q[$];
    logic [6:0] sb_exp;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .CNT_WIDTH  (CNT_WIDTH),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst        (rst),
        .bus        (bus),
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o),
        .err_o      (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Outputs are combinational, so they are sampled mid-cycle on the falling edge.
    always @(negedge clk_i) begin
        if (sb_q.size() != 0) begin
            sb_exp = sb_q.pop_front();
            check_eq("outs", {25'd0, bus.PC_stall_o, bus.F_stall_o, bus.D_stall_o, bus.E_stall_o,
                              bus.F_bubble_o, bus.D_bubble_o, bus.M_bubble_o}, {25'd0, sb_exp});
        end
    end

    task automatic tick(input logic [6:0] exp);
        sb_q.push_back(exp);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.FD_rs1_i       = '0;
        bus.FD_rs2_i       = '0;
        bus.FD_use_rs1_i   = 1'b0;
        bus.FD_use_rs2_i   = 1'b0;
        bus.DD_load_op_i   = '0;
        bus.DD_need_dstE_i = 1'b0;
        bus.DD_dstE_i      = '0;
        bus.E_mispredict_i = 1'b0;
        bus.M_req_i        = 1'b0;
        bus.M_ack_i        = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] dst, input logic [4:0] rs1, input logic use1,
                            input logic [4:0] rs2, input logic use2);
        bus.DD_load_op_i   = 3'd2;
        bus.DD_need_dstE_i = 1'b1;
        bus.DD_dstE_i      = dst;
        bus.FD_rs1_i       = rs1;
        bus.FD_use_rs1_i   = use1;
        bus.FD_rs2_i       = rs2;
        bus.FD_use_rs2_i   = use2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle();
        @(posedge clk_i);
        #1;

        // reset forces bubbles even with a live hazard on the inputs
        load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        tick(c_rst);
        check_eq("rst_stall_cnt", stall_cnt_o, 0);
        check_eq("rst_flush_cnt", flush_cnt_o, 0);
        check_eq("rst_err", {31'd0, err_o}, 0);
        idle();
        rst = 1'b1;
        tick(c_none);

        // load-use on rs1, then same pattern with dst = x0
        load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        tick(c_lu);
        idle();
        tick(c_none);
        check_eq("lu_stall_cnt", stall_cnt_o, 1);
        load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        tick(c_none);
        load_use(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
        tick(c_lu);
        load_use(5'd7, 5'd1, 1'b1, 5'd7, 1'b0);
        tick(c_none);
        bus.DD_need_dstE_i = 1'b0;
        bus.FD_use_rs2_i   = 1'b1;
        tick(c_none);
        check_eq("lu2_stall_cnt", stall_cnt_o, 2);

        // mispredict outranks load-use
        check_eq("flush_cnt_before", flush_cnt_o, 0);
        load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        bus.E_mispredict_i = 1'b1;
        tick(c_fl);
        idle();
        check_eq("flush_cnt_after", flush_cnt_o, 1);
        check_eq("flush_stall_cnt", stall_cnt_o, 2);

        // 4-cycle request, ack in the 4th
        bus.M_req_i = 1'b1;
        for (int i = 0; i < 3; i++) tick(c_mw);
        bus.M_ack_i = 1'b1;
        tick(c_none);
        idle();
        tick(c_none);
        check_eq("mw_stall_cnt", stall_cnt_o, 5);
        check_eq("mw_err", {31'd0, err_o}, 0);

        // same wait with mispredict held: flush lands in the ack cycle
        bus.M_req_i        = 1'b1;
        bus.E_mispredict_i = 1'b1;
        for (int i = 0; i < 3; i++) tick(c_mw);
        check_eq("mw_flush_held", flush_cnt_o, 1);
        bus.M_ack_i = 1'b1;
        tick(c_fl);
        idle();
        check_eq("mw_flush_cnt", flush_cnt_o, 2);
        check_eq("mw2_stall_cnt", stall_cnt_o, 8);

        // ack together with req: no stall
        bus.M_req_i = 1'b1;
        bus.M_ack_i = 1'b1;
        tick(c_none);
        idle();
        tick(c_none);
        check_eq("ack_same_stall_cnt", stall_cnt_o, 8);

        // timeout: err rises after the 4th MEM_WAIT cycle and stays
        bus.M_req_i = 1'b1;
        tick(c_mw);
        check_eq("to_err_entry", {31'd0, err_o}, 0);
        for (int k = 1; k <= 9; k++) begin
            tick(c_mw);
            check_eq("to_err_wait", {31'd0, err_o}, (k >= MEM_TIMEOUT) ? 1 : 0);
        end
        bus.M_ack_i = 1'b1;
        tick(c_none);
        idle();
        tick(c_none);
        check_eq("to_err_after_ack", {31'd0, err_o}, 1);
        check_eq("to_stall_cnt", stall_cnt_o, 18);

        // reset mid-wait
        bus.M_req_i = 1'b1;
        tick(c_mw);
        tick(c_mw);
        rst = 1'b0;
        tick(c_rst);
        check_eq("midrst_stall_cnt", stall_cnt_o, 0);
        check_eq("midrst_flush_cnt", flush_cnt_o, 0);
        check_eq("midrst_err", {31'd0, err_o}, 0);
        rst = 1'b1;

        // request dropped without ack in MEM_WAIT
        tick(c_mw);
        check_eq("drop_err_before", {31'd0, err_o}, 0);
        bus.M_req_i = 1'b0;
        tick(c_none);
        check_eq("drop_err", {31'd0, err_o}, 1);
        check_eq("drop_stall_cnt", stall_cnt_o, 1);
        bus.M_req_i = 1'b1;
        bus.M_ack_i = 1'b1;
        tick(c_none);
        idle();
        tick(c_none);
        check_eq("drop_err_sticky", {31'd0, err_o}, 1);

        rst = 1'b0;
        tick(c_rst);
        check_eq("final_rst_err", {31'd0, err_o}, 0);

        @(negedge clk_i);
        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and stall controller for the 5-stage core. It produces the `*_stall` / `*_bubble` controls consumed by `fetch_reg`, `decode_reg`, `execute_reg` and `memory_reg`, so it is the driving end of the stall/bubble protocol those registers receive. It resolves load-use hazards, execute-stage branch mispredict flushes and multi-cycle data-memory waits. It also keeps a memory-wait FSM with a timeout error and performance counters.

## Interface
Parameters:
- `CNT_WIDTH`, 32 — width of the performance counters.
- `MEM_TIMEOUT`, 255 — number of consecutive wait cycles that sets `err_o`.

Ports:
- `clk_i` in 1 — single clock.
- `rst` in 1 — asynchronous, active-low reset.
- `FD_rs1_i`, `FD_rs2_i` in 5 each — source register indices of the instruction in decode (`fetch_reg` output).
- `FD_use_rs1_i`, `FD_use_rs2_i` in 1 each — the decode instruction really reads rs1 / rs2.
- `DD_load_op_i` in `LOAD_WIDTH` — load op of the instruction in execute (`decode_reg` output); nonzero means it is a load.
- `DD_need_dstE_i` in 1, `DD_dstE_i` in 5 — destination-register info of the instruction in execute.
- `E_mispredict_i` in 1 — the branch in execute was mispredicted; the redirect is valid this cycle.
- `M_req_i` in 1, `M_ack_i` in 1 — data-memory request / acknowledge for the memory stage.
- `PC_stall_o`, `F_stall_o`, `D_stall_o`, `E_stall_o` out 1 each — hold the PC / the matching pipeline register.
- `F_bubble_o`, `D_bubble_o`, `M_bubble_o` out 1 each — load a nop into the matching pipeline register.
- `stall_cnt_o` out `CNT_WIDTH` — cycles in which any stall was asserted.
- `flush_cnt_o` out `CNT_WIDTH` — number of mispredict flushes applied.
- `err_o` out 1 — sticky flag for a memory timeout or protocol violation.

## Operation
- **Load-use hazard (`lu`)** is true when all of these hold:
  - `DD_load_op_i != 0` and `DD_need_dstE_i` and `DD_dstE_i != 0`;
  - and either (`FD_use_rs1_i` and `FD_rs1_i == DD_dstE_i`) or the same test for rs2.
- **Memory wait (`mw`)**:
  - in RUN: `M_req_i & ~M_ack_i`;
  - in MEM_WAIT: `~M_ack_i`.
- **Priority**: `mw` > `E_mispredict_i` > `lu`. Only one action is applied per cycle.
  - `mw`: `PC_stall_o`, `F_stall_o`, `D_stall_o`, `E_stall_o` = 1 and `M_bubble_o` = 1. A pending mispredict or load-use is not applied; it is re-evaluated after release, because the execute and decode contents are frozen.
  - mispredict: `F_bubble_o` = `D_bubble_o` = 1 and all stalls = 0, even if `lu` is also true. `flush_cnt_o` += 1.
  - `lu` alone: `PC_stall_o` = `F_stall_o` = 1 and `D_bubble_o` = 1.
  - otherwise all outputs are 0.
- **FSM states**:
  - RUN → MEM_WAIT on `M_req_i & ~M_ack_i`.
  - MEM_WAIT → RUN on `M_ack_i`. Stalls drop combinationally in the ack cycle.
  - MEM_WAIT → RUN when `M_req_i` drops without an ack. This is a protocol violation: set `err_o` and release the stalls that cycle.
- **Wait counter**:
  - width `$clog2(MEM_TIMEOUT+1)`; cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle, saturating.
  - when it reaches `MEM_TIMEOUT`, set `err_o`. The stall continues until ack.
- **`err_o`** stays set until reset.
- **`stall_cnt_o`** += 1 in every cycle where any `*_stall_o` is 1.
- **Counter width**: both counters wrap modulo 2^`CNT_WIDTH`.

## Timing
- The stall/bubble outputs are combinational from the inputs and the registered state, with zero latency. The consuming registers act on the same clock edge.
- The FSM, the counters and `err_o` update on `posedge clk_i`.
- While `rst` = 0:
  - state = RUN, counters = 0, `err_o` = 0;
  - all `*_stall_o` are forced to 0 and all `*_bubble_o` are forced to 1.
- Reset asserted mid-wait returns to RUN immediately, with no error.
- An `M_ack_i` in the same cycle as `M_req_i` gives zero stall cycles and no FSM transition.
- A wait of N cycles before ack gives exactly N stall cycles, and `stall_cnt_o` increases by N.

## Structure
- `define.v` gains:
  - `ST_RUN` / `ST_MEM_WAIT` state encodings;
  - the default counter width `CNT_WIDTH`;
  - `LOAD_WIDTH`, reused from the existing definitions.
- One sub-module is natural: `hazard_detect`, a purely combinational block computing `lu`. The FSM, the priority mux and the counters stay in `pipe_ctrl`.

## Test plan
- Load to x5 in execute with the decode instruction using rs1 = x5 → exactly 1 cycle of `PC_stall_o`/`F_stall_o` = 1 and `D_bubble_o` = 1. Repeat with `DD_dstE_i` = 0 → no stall.
- `E_mispredict_i` = 1 for 1 cycle together with `lu` = 1 → `F_bubble_o` = `D_bubble_o` = 1, `F_stall_o` = 0, `flush_cnt_o` goes 0 → 1.
- `M_req_i` held for 4 cycles with ack in the 4th → stalls = 1 and `M_bubble_o` = 1 for 3 cycles, `stall_cnt_o` = 3. With `E_mispredict_i` held throughout, the flush occurs in the ack cycle.
- `MEM_TIMEOUT` = 4 and ack after 10 cycles → `err_o` rises after the 4th wait cycle, stays set after ack, and is cleared only by reset.
- `M_req_i` dropped in MEM_WAIT without ack → `err_o` = 1 and state returns to RUN. Separately, asserting `rst` low mid-wait → all bubbles = 1, stalls = 0, counters = 0.
